// File: rtl/toymips_pkg.sv
// Shared constants and types for the toyMIPS fetch path.
package toymips_pkg;

  localparam int PC_INC    = 4;
  localparam int J_INDEX_W = 26;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

endpackage

// File: rtl/branch_pc_unit_pc_adder.sv
// Unsigned W-bit adder; the carry out is dropped so results wrap modulo 2^W.
module pc_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/branch_pc_unit.sv
// Architectural PC register with next-PC selection for beq/bne, j and jr,
// plus a one-cycle flush pulse and a saturating count of taken redirects.
module branch_pc_unit
  import toymips_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                IMM_W    = 16,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 br_valid,
  input  logic                 br_is_bne,
  input  logic                 zero,
  input  logic [IMM_W-1:0]     br_imm,
  input  logic                 j_valid,
  input  logic [J_INDEX_W-1:0] j_index,
  input  logic                 jr_valid,
  input  logic [ADDR_W-1:0]    jr_target,
  output logic [ADDR_W-1:0]    pc,
  output logic [ADDR_W-1:0]    pc_plus4,
  output logic                 flush,
  output logic                 addr_err,
  output logic [CNT_W-1:0]     taken_cnt
);

  // Wide enough to hold the shifted immediate before truncating to ADDR_W.
  localparam int OFF_W = (IMM_W + 2 > ADDR_W) ? IMM_W + 2 : ADDR_W;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 flush_q, flush_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [OFF_W-1:0]     off_wide;
  logic [ADDR_W-1:0]    br_off;
  logic [ADDR_W-1:0]    br_target;
  logic [ADDR_W-1:0]    j_target;
  logic [ADDR_W-1:0]    jr_rt;
  logic [J_INDEX_W+1:0] j_full;
  logic                 br_taken;
  npc_sel_e             sel;

  pc_adder #(.W(ADDR_W)) u_inc_add (
    .a   (pc_q),
    .b   (INC),
    .sum (pc_plus4)
  );

  assign off_wide = {{(OFF_W - IMM_W){br_imm[IMM_W-1]}}, br_imm} << 2;
  assign br_off   = off_wide[ADDR_W-1:0];

  pc_adder #(.W(ADDR_W)) u_br_add (
    .a   (pc_plus4),
    .b   (br_off),
    .sum (br_target)
  );

  assign j_full = {j_index, 2'b00};

  // Wide PCs keep the upper region of pc+4, MIPS-style.
  generate
    if (ADDR_W <= 28) begin : g_jt_narrow
      assign j_target = j_full[ADDR_W-1:0];
    end else begin : g_jt_wide
      assign j_target = {pc_plus4[ADDR_W-1:28], j_full};
    end
  endgenerate

  assign jr_rt    = {jr_target[ADDR_W-1:2], 2'b00};
  assign br_taken = br_valid & (br_is_bne ? ~zero : zero);

  always_comb begin
    sel = NPC_SEQ;
    if (jr_valid)      sel = NPC_JR;
    else if (j_valid)  sel = NPC_J;
    else if (br_taken) sel = NPC_BR;
  end

  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      case (sel)
        NPC_JR:  pc_d = jr_rt;
        NPC_J:   pc_d = j_target;
        NPC_BR:  pc_d = br_target;
        default: pc_d = pc_plus4;
      endcase
      flush_d = (sel != NPC_SEQ);
      if (flush_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
      if (jr_valid && (jr_target[1:0] != 2'b00)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign flush     = flush_q;
  assign addr_err  = err_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: a reference model checked every cycle,
// plus literal expectations from the walkthrough scenarios.
module tb_branch_pc_unit;

  localparam int    ADDR_W = 8;
  localparam longint M     = 256;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_is_bne;
  logic        zero;
  logic [15:0] br_imm;
  logic        j_valid;
  logic [25:0] j_index;
  logic        jr_valid;
  logic [7:0]  jr_target;

  logic [7:0]  pc, pc_plus4;
  logic        flush, addr_err;
  logic [15:0] taken_cnt;
  logic [7:0]  pc_c2, pc_plus4_c2;
  logic        flush_c2, addr_err_c2;
  logic [1:0]  taken_cnt_c2;

  int total;
  int bad;

  branch_pc_unit #(.ADDR_W(ADDR_W), .RESET_PC(8'h00), .IMM_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
    .br_is_bne(br_is_bne), .zero(zero), .br_imm(br_imm), .j_valid(j_valid),
    .j_index(j_index), .jr_valid(jr_valid), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .addr_err(addr_err),
    .taken_cnt(taken_cnt)
  );

  branch_pc_unit #(.ADDR_W(ADDR_W), .RESET_PC(8'h00), .IMM_W(16), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
    .br_is_bne(br_is_bne), .zero(zero), .br_imm(br_imm), .j_valid(j_valid),
    .j_index(j_index), .jr_valid(jr_valid), .jr_target(jr_target),
    .pc(pc_c2), .pc_plus4(pc_plus4_c2), .flush(flush_c2), .addr_err(addr_err_c2),
    .taken_cnt(taken_cnt_c2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_pc;
  bit     m_flush;
  bit     m_err;
  int     m_cnt;

  always @(posedge clk or negedge rst_n) begin
    longint p4;
    longint off;
    bit     redirect;
    if (!rst_n) begin
      m_pc = 0; m_flush = 0; m_err = 0; m_cnt = 0;
    end else if (stall) begin
      m_flush = 0;
    end else begin
      p4 = (m_pc + 4) % M;
      redirect = 1;
      if (jr_valid) begin
        m_pc = longint'(jr_target) - (longint'(jr_target) % 4);
        if (longint'(jr_target) % 4 != 0) m_err = 1;
      end else if (j_valid) begin
        m_pc = (longint'(j_index) * 4) % M;
      end else if (br_valid && (br_is_bne ? !zero : zero)) begin
        off = longint'(br_imm);
        if (off >= 32768) off = off - 65536;
        m_pc = (((p4 + off * 4) % M) + M) % M;
      end else begin
        m_pc = p4;
        redirect = 0;
      end
      m_flush = redirect;
      if (redirect) m_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("m_pc",       32'(pc),           32'(m_pc));
      check("m_pc_plus4", 32'(pc_plus4),     32'((m_pc + 4) % M));
      check("m_flush",    32'(flush),        32'(m_flush));
      check("m_addr_err", 32'(addr_err),     32'(m_err));
      check("m_cnt16",    32'(taken_cnt),    32'((m_cnt > 65535) ? 65535 : m_cnt));
      check("m_pc_c2",    32'(pc_c2),        32'(m_pc));
      check("m_cnt2",     32'(taken_cnt_c2), 32'((m_cnt > 3) ? 3 : m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    stall = 0; br_valid = 0; br_is_bne = 0; zero = 0; br_imm = '0;
    j_valid = 0; j_index = '0; jr_valid = 0; jr_target = '0;
  endtask

  task automatic set_br(input logic bne, input logic z, input logic [15:0] imm);
    idle();
    br_valid = 1; br_is_bne = bne; zero = z; br_imm = imm;
  endtask

  task automatic set_j(input logic [25:0] idx);
    idle();
    j_valid = 1; j_index = idx;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] e_pc, input logic e_fl,
                              input logic [15:0] e_cnt);
    check({tag, "_pc"},    32'(pc),        32'(e_pc));
    check({tag, "_flush"}, 32'(flush),     32'(e_fl));
    check({tag, "_cnt"},   32'(taken_cnt), 32'(e_cnt));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    expect_state("rst", 8'h00, 1'b0, 16'd0);
    check("rst_err", 32'(addr_err), 32'd0);

    // sequential fetch from reset
    cyc(); expect_state("seq1", 8'h04, 1'b0, 16'd0);
    cyc(); expect_state("seq2", 8'h08, 1'b0, 16'd0);
    cyc(); expect_state("seq3", 8'h0C, 1'b0, 16'd0);
    cyc(); expect_state("seq4", 8'h10, 1'b0, 16'd0);

    // beq taken, j back, bne not taken
    set_br(1'b0, 1'b1, 16'h0003);
    cyc(); expect_state("beq_t", 8'h20, 1'b1, 16'd1);
    set_j(26'h4);
    cyc(); expect_state("j_10", 8'h10, 1'b1, 16'd2);
    set_br(1'b1, 1'b1, 16'h0003);
    cyc(); expect_state("bne_nt", 8'h14, 1'b0, 16'd2);

    // negative offset, then wrap from 0xFC
    set_j(26'h2);
    cyc(); expect_state("j_08", 8'h08, 1'b1, 16'd3);
    set_br(1'b0, 1'b1, 16'hFFFE);
    cyc(); expect_state("beq_neg", 8'h04, 1'b1, 16'd4);
    set_j(26'h3F);
    cyc(); expect_state("j_fc", 8'hFC, 1'b1, 16'd5);
    check("p4_wrap", 32'(pc_plus4), 32'h00);
    idle();
    cyc(); expect_state("wrap", 8'h00, 1'b0, 16'd5);
    check("wrap_err", 32'(addr_err), 32'd0);

    // jr beats j and branch in the same cycle; misaligned target is sticky
    set_j(26'h8);
    cyc(); expect_state("j_20", 8'h20, 1'b1, 16'd6);
    set_br(1'b0, 1'b1, 16'h0001);
    j_valid = 1; j_index = 26'h10; jr_valid = 1; jr_target = 8'h33;
    cyc(); expect_state("jr_pri", 8'h30, 1'b1, 16'd7);
    check("jr_err", 32'(addr_err), 32'd1);
    idle();
    cyc(); check("err_hold1", 32'(addr_err), 32'd1);
    cyc(); check("err_hold2", 32'(addr_err), 32'd1);

    // stall holds PC and ignores the jump until it drops
    set_j(26'h10);
    cyc(); expect_state("j_40", 8'h40, 1'b1, 16'd8);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_state("stall", 8'h40, 1'b0, 16'd8);
    end
    stall = 0;
    cyc(); expect_state("unstall", 8'h40, 1'b1, 16'd9);

    // taken bne to pc+4 still counts as a redirect
    set_br(1'b1, 1'b0, 16'h0000);
    cyc(); expect_state("bne_p4", 8'h44, 1'b1, 16'd10);

    // asynchronous reset between edges
    idle();
    #2;
    rst_n = 0;
    #1;
    expect_state("arst", 8'h00, 1'b0, 16'd0);
    check("arst_err", 32'(addr_err), 32'd0);
    check("arst_cnt2", 32'(taken_cnt_c2), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // misaligned jr under stall must not set the error
    stall = 1; jr_valid = 1; jr_target = 8'h13;
    cyc(); expect_state("stall_jr", 8'h00, 1'b0, 16'd0);
    check("stall_jr_err", 32'(addr_err), 32'd0);

    // five taken branches: narrow counter saturates at 3
    set_br(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) cyc();
    check("cnt16_5", 32'(taken_cnt), 32'd5);
    check("cnt2_sat", 32'(taken_cnt_c2), 32'd3);
    check("pc_5br", 32'(pc), 32'h14);
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
